// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake bundle for the sequential divider.
//   master : controller side, drives start, dividend, divisor
//   slave  : divider side, drives busy, done, quotient, remainder, div_by_zero
// WIDTH must match the WIDTH of the attached seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract integer divider, one quotient bit per clock.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : seq_divider_if.slave
//              start/dividend/divisor in; busy, done (1-cycle pulse),
//              quotient/remainder/div_by_zero out, held until the next done.
// Latency: done is high WIDTH cycles after the accepting edge; a zero divisor
// finishes in one cycle. start is accepted in IDLE and in DONE (back-to-back).
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands, truncating
// division, remainder carries the dividend's sign. Undefined: unsigned only.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] wq_q, wq_d;         // working quotient / dividend shifter
    logic [WIDTH-1:0] dvs_q, dvs_d;       // latched divisor (magnitude)
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, wq_nx;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    // most-negative has no positive twin, but its magnitude is still exact
    // as an unsigned value, so -MIN/-1 falls out as MIN with no special case
    assign quo_fix = neg_quo_q ? -wq_nx  : wq_nx;
    assign rem_fix = neg_rem_q ? -rem_nx : rem_nx;
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign quo_fix = wq_nx;
    assign rem_fix = rem_nx;
`endif

    // One restoring step. The shifted remainder is WIDTH+1 bits, so the
    // subtract is judged by a full-width compare rather than a borrow bit.
    assign rem_sh = {rem_q, wq_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};
    assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
    assign wq_nx  = {wq_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wq_d    = wq_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        remo_d  = bus.dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        wq_d    = dvd_mag;
                        dvs_d   = dvs_mag;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_d = bus.dividend[WIDTH-1];
`endif
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                wq_d  = wq_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = quo_fix;
                    remo_d  = rem_fix;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            wq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wq_q    <= wq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative shift-subtract (restoring) integer divider; the inverse of the shift-add multiplier in the arithmetic library.
- Produces quotient and remainder one bit per clock.
- Serves the polynomial evaluator datapath for normalisation and scaling steps.
- Start/done handshake with the controlling FSM; results held until the next accepted start.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (legal: 2..32)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  high while an operation is in RUN
- done  output  1  one-cycle pulse when results are valid
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  set with done when divisor==0, held with results

Behaviour:
- Reset: on rst=1 at a clock edge:
  - all outputs go to 0;
  - state goes to IDLE;
  - internal shift register and counter are cleared.
  - rst overrides start and aborts any in-flight operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE with start=1, divisor!=0 (edge E0):
  - latch operands;
  - partial remainder = 0, working quotient = dividend;
  - counter = WIDTH;
  - go to RUN, busy=1.
- IDLE with start=1, divisor==0 (edge E0): go directly to DONE with
  - quotient = all ones,
  - remainder = dividend,
  - div_by_zero=1,
  - done=1 in the cycle after E0.
- RUN, each edge:
  - {rem, q} shifted left one bit;
  - trial = rem - divisor, computed WIDTH+1 bits wide;
  - if trial is non-negative: rem = trial, q LSB = 1; else q LSB = 0;
  - counter decrements.
  - On the edge where counter reaches 0 (edge E_WIDTH): outputs are registered, state goes to DONE, busy=0, done=1.
- Latency: done is visible exactly WIDTH cycles after the start-accept edge (8 for the default).
- DONE lasts one cycle, then returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle bubble).
- start while busy=1 is ignored; operands changing during RUN have no effect.
- quotient, remainder and div_by_zero change only at a done edge or on reset.
  - div_by_zero clears at the next done for a nonzero divisor.
- Identities that must always hold (unsigned): dividend == quotient*divisor + remainder, and remainder < divisor, for divisor!=0.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN
- Defined:
  - operands are two's complement;
  - magnitudes are divided by the unsigned core;
  - quotient is negated when the operand signs differ (truncation toward zero);
  - remainder takes the sign of the dividend.
  - Sign fix-up is applied at the DONE registration, so latency is unchanged.
  - Overflow case: most-negative / -1 gives quotient = most-negative, remainder 0, no flag.
  - Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- Undefined: purely unsigned operation; no sign logic is synthesised.

Test Plan:
- Reset/idle: rst held 3 cycles then released, no start -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Basic unsigned (WIDTH=8): dividend=200, divisor=7 ->
  - busy high for 8 cycles;
  - done pulse exactly 8 cycles after accept;
  - quotient=28, remainder=4.
- Boundary values:
  - 255/1 -> q=255, r=0;
  - 5/9 -> q=0, r=5;
  - 255/255 -> q=1, r=0.
  - Each case back-to-back, with start asserted during DONE -> no idle cycle between operations.
- Divide by zero: dividend=77, divisor=0 ->
  - done on the cycle after accept;
  - q=0xFF, r=77, div_by_zero=1;
  - a following 10/3 gives q=3, r=1 and clears div_by_zero.
- Abort and ignore:
  - start 100/3; assert start with 50/5 at cycle 3 -> ignored, result q=33, r=1.
  - Repeat 100/3 and assert rst at cycle 4 -> no done pulse, all outputs 0.
- Signed (SEQ_DIVIDER_SIGNED_EN):
  - -100/7 -> q=0xF2 (-14), r=0xFE (-2);
  - 100/-7 -> q=-14, r=2;
  - -128/-1 -> q=0x80, r=0.
